// File: rtl/nocpe_result_drain.sv
// nocpe_result_drain: gates operand feed for k_len MAC cycles on a 1xNPE PE chain, snapshots every accumulator after the skew, clears the array and streams the results out
// Ports: clk, rst (async, active-low); start/k_len job request; busy/feed_en/pe_clr job control;
//        c_flat PE accumulators in; out_valid/out_ready/out_data/out_idx/out_last result stream; done end-of-job pulse
module nocpe_result_drain #(
   parameter int DW = 32,
   parameter int NPE = 2,
   parameter int PIPE_LAT = 1,
   parameter int K_W = 8,
   localparam int IW = NPE > 1 ? $clog2(NPE) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [K_W-1:0]  k_len,
   output logic            busy,
   output logic            feed_en,
   input  logic [NPE*DW-1:0] c_flat,
   output logic            pe_clr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [IW-1:0]   out_idx,
   output logic            out_last,
   output logic            done
);
   localparam int SL = PIPE_LAT + NPE - 1;
   localparam int WW = $clog2(SL + 1);
   typedef enum logic [2:0] {IDLE, FEED, SKEW, CLEAR, DRAIN} state_t;
   state_t state, nxt;
   logic [K_W-1:0] cnt;
   logic [WW-1:0] w;
   logic [IW-1:0] idx;
   logic [DW-1:0] snap [NPE];
   logic done_q;
   assign busy = state != IDLE;
   assign feed_en = state == FEED;
   assign pe_clr = state == CLEAR;
   assign out_valid = state == DRAIN;
   assign out_data = snap[idx];
   assign out_idx = idx;
   assign out_last = idx == IW'(NPE - 1);
   assign done = done_q;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start && k_len != '0 ? FEED : IDLE;
         FEED:    nxt = cnt == K_W'(1) ? SKEW : FEED;
         SKEW:    nxt = w == WW'(SL) ? CLEAR : SKEW;
         CLEAR:   nxt = DRAIN;
         DRAIN:   nxt = out_ready && out_last ? IDLE : DRAIN;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         w <= '0;
         idx <= '0;
         done_q <= 1'b0;
         for (int i = 0; i < NPE; i++) snap[i] <= '0;
      end else begin
         state <= nxt;
         done_q <= state == DRAIN && out_ready && out_last;
         cnt <= state == IDLE ? k_len : state == FEED ? cnt - K_W'(1) : cnt;
         // w counts skew cycles; the last feed cycle is w=0, so the first skew cycle is w=1
         w <= state == FEED ? WW'(1) : state == SKEW ? w + WW'(1) : '0;
         idx <= state == CLEAR ? '0 : state == DRAIN && out_ready ? idx + IW'(1) : idx;
         // b forwarding delays PE i by i cycles beyond the pipeline latency
         for (int i = 0; i < NPE; i++)
            if (state == SKEW && w == WW'(PIPE_LAT + i)) snap[i] <= c_flat[i*DW +: DW];
      end
   end
endmodule

// File: tb/tb_nocpe_result_drain.sv
// tb_nocpe_result_drain: directed bench for nocpe_result_drain against a 1x2 chained-PE model
module tb_nocpe_result_drain;
   logic clk = 0;
   logic rst = 0;
   logic start = 0;
   logic [7:0] k_len = 0;
   logic busy, feed_en, pe_clr, out_valid, out_last, done;
   logic out_ready = 1;
   logic [31:0] out_data;
   logic [0:0] out_idx;
   logic [63:0] c_flat;
   logic [31:0] a0 = 0, b0 = 0, a1 = 5, c0 = 0, c1 = 0, bd = 0;
   logic [31:0] op_a [4], op_b [4];
   int checks = 0, failures = 0;
   int r_nfeed, r_nclr, r_ndone, r_nw, r_hold;
   logic [31:0] r_w [2], r_hold_data;
   logic r_idx [2], r_last [2];
   bit r_ovl, r_to, r_busy, r_hold_ok;

   always #5 clk = ~clk;

   nocpe_result_drain #(.DW(32), .NPE(2), .PIPE_LAT(1), .K_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .feed_en(feed_en),
      .c_flat(c_flat), .pe_clr(pe_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .done(done));

   // PE0 accumulates a0*b0; PE1 accumulates a1*b0 with b0 forwarded one cycle later
   assign c_flat = {c1, c0};
   always @(posedge clk or negedge rst) begin
      if (!rst || pe_clr) begin
         c0 <= 0; c1 <= 0; bd <= 0;
      end else begin
         c0 <= c0 + (feed_en ? a0 * b0 : 32'd0);
         bd <= feed_en ? b0 : 32'd0;
         c1 <= c1 + a1 * bd;
      end
   end

   // Starts a job at the current (post-negedge) time and records what the DUT does
   task automatic run_job(input logic [7:0] k, input int tail, input int stall, input bit poke, input int maxc);
      int after = -1;
      bit fin = 0;
      r_nfeed = 0; r_nclr = 0; r_ndone = 0; r_nw = 0; r_hold = 0;
      r_ovl = 0; r_to = 1; r_busy = 0; r_hold_ok = 1; r_hold_data = 0;
      r_w[0] = 'x; r_w[1] = 'x; r_idx[0] = 'x; r_idx[1] = 'x; r_last[0] = 'x; r_last[1] = 'x;
      start = 1; k_len = k; out_ready = stall == 0;
      for (int c = 0; c < maxc && !fin; c++) begin
         @(negedge clk);
         start = 0;
         if (busy) r_busy = 1;
         if ($countones({feed_en, pe_clr, out_valid}) > 1) r_ovl = 1;
         if (feed_en) begin
            a0 = op_a[r_nfeed]; b0 = op_b[r_nfeed];
            r_nfeed++;
            if (poke && r_nfeed == 1) start = 1;
         end else begin
            a0 = 0; b0 = 0;
         end
         if (pe_clr) r_nclr++;
         if (out_valid) begin
            if (stall > 0 && r_nw == 0) begin
               if (r_hold == 0) r_hold_data = out_data;
               else if (out_data !== r_hold_data || out_idx !== 1'b0) r_hold_ok = 0;
               r_hold++; stall--; out_ready = 0;
            end else begin
               out_ready = 1;
               if (r_nw < 2) begin
                  r_w[r_nw] = out_data; r_idx[r_nw] = out_idx; r_last[r_nw] = out_last;
               end
               r_nw++;
               if (poke && r_nw == 1) start = 1;
            end
         end
         if (done) begin
            r_ndone++;
            if (after < 0) begin after = tail; r_to = 0; end
         end
         if (after == 0) fin = 1;
         else if (after > 0) after--;
      end
   endtask

   task automatic test_reset;
      #1;
      if ({busy, feed_en, pe_clr, out_valid, out_last, done} !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=000000", {busy, feed_en, pe_clr, out_valid, out_last, done});
      end
      checks++;
      if (out_data !== 32'd0 || out_idx !== 1'b0) begin
         failures++; $display("FAIL reset_data got=%0d/%0d exp=0/0", out_data, out_idx);
      end
      checks++;
      @(negedge clk); rst = 1;
      @(negedge clk);
   endtask

   task automatic test_single;
      op_a[0] = 5; op_b[0] = 10;
      run_job(8'd1, 2, 0, 0, 60);
      if (r_to) begin failures++; $display("FAIL t1_timeout got=no_done exp=done"); end
      checks++;
      if (r_w[0] !== 32'd50 || r_w[1] !== 32'd50) begin
         failures++; $display("FAIL t1_words got=%0d,%0d exp=50,50", r_w[0], r_w[1]);
      end
      checks++;
      if ({r_idx[0], r_last[0], r_idx[1], r_last[1]} !== 4'b0011) begin
         failures++; $display("FAIL t1_idx_last got=%b exp=0011", {r_idx[0], r_last[0], r_idx[1], r_last[1]});
      end
      checks++;
      if (r_nfeed !== 1 || r_nclr !== 1 || r_ndone !== 1 || r_nw !== 2) begin
         failures++; $display("FAIL t1_counts got=feed%0d clr%0d done%0d words%0d exp=1,1,1,2", r_nfeed, r_nclr, r_ndone, r_nw);
      end
      checks++;
      if (r_ovl) begin failures++; $display("FAIL t1_overlap got=1 exp=0"); end
      checks++;
   endtask

   task automatic test_two_cycle;
      op_a[0] = 5; op_b[0] = 10; op_a[1] = 20; op_b[1] = 15;
      run_job(8'd2, 2, 0, 0, 60);
      if (r_w[0] !== 32'd350 || r_w[1] !== 32'd125) begin
         failures++; $display("FAIL t2_words got=%0d,%0d exp=350,125", r_w[0], r_w[1]);
      end
      checks++;
      if (r_nfeed !== 2 || r_ndone !== 1) begin
         failures++; $display("FAIL t2_counts got=feed%0d done%0d exp=2,1", r_nfeed, r_ndone);
      end
      checks++;
   endtask

   task automatic test_backpressure;
      op_a[0] = 5; op_b[0] = 10; op_a[1] = 20; op_b[1] = 15;
      run_job(8'd2, 2, 3, 0, 60);
      if (r_hold !== 3 || !r_hold_ok || r_hold_data !== 32'd350) begin
         failures++; $display("FAIL t3_hold got=n%0d ok%0d d%0d exp=n3 ok1 d350", r_hold, r_hold_ok, r_hold_data);
      end
      checks++;
      if (r_w[0] !== 32'd350 || r_w[1] !== 32'd125 || r_idx[0] !== 1'b0 || r_idx[1] !== 1'b1) begin
         failures++; $display("FAIL t3_words got=%0d,%0d exp=350,125", r_w[0], r_w[1]);
      end
      checks++;
      if (r_nw !== 2 || r_ndone !== 1) begin
         failures++; $display("FAIL t3_counts got=words%0d done%0d exp=2,1", r_nw, r_ndone);
      end
      checks++;
   endtask

   task automatic test_start_ignored;
      op_a[0] = 5; op_b[0] = 10; op_a[1] = 20; op_b[1] = 15;
      run_job(8'd2, 4, 0, 1, 60);
      if (r_nw !== 2 || r_ndone !== 1 || r_nfeed !== 2 || r_nclr !== 1) begin
         failures++; $display("FAIL t4_counts got=words%0d done%0d feed%0d clr%0d exp=2,1,2,1", r_nw, r_ndone, r_nfeed, r_nclr);
      end
      checks++;
      if (r_w[0] !== 32'd350 || r_w[1] !== 32'd125) begin
         failures++; $display("FAIL t4_words got=%0d,%0d exp=350,125", r_w[0], r_w[1]);
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL t4_idle got=%b exp=0", busy); end
      checks++;
   endtask

   task automatic test_back_to_back;
      op_a[0] = 5; op_b[0] = 10;
      run_job(8'd1, 0, 0, 0, 60);
      if (done !== 1'b1 || busy !== 1'b0 || r_w[0] !== 32'd50) begin
         failures++; $display("FAIL t_b2b_first got=done%b busy%b w%0d exp=1,0,50", done, busy, r_w[0]);
      end
      checks++;
      op_a[0] = 5; op_b[0] = 10; op_a[1] = 20; op_b[1] = 15;
      run_job(8'd2, 2, 0, 0, 60);
      if (r_nfeed !== 2 || r_ndone !== 1 || r_w[0] !== 32'd350 || r_w[1] !== 32'd125) begin
         failures++; $display("FAIL t_b2b_second got=feed%0d done%0d w%0d,%0d exp=2,1,350,125", r_nfeed, r_ndone, r_w[0], r_w[1]);
      end
      checks++;
   endtask

   task automatic test_reset_mid_drain;
      int n = 0;
      op_a[0] = 5; op_b[0] = 10;
      start = 1; k_len = 8'd1; out_ready = 1;
      @(negedge clk); start = 0;
      a0 = 0; b0 = 0;
      while (!out_valid && n < 40) begin
         if (feed_en) begin a0 = op_a[0]; b0 = op_b[0]; end else begin a0 = 0; b0 = 0; end
         @(negedge clk); n++;
      end
      a0 = 0; b0 = 0;
      if (!out_valid) begin failures++; $display("FAIL t5_drain_timeout got=0 exp=1"); end
      checks++;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_idx !== 1'b1) begin
         failures++; $display("FAIL t5_word1 got=v%b i%b exp=1,1", out_valid, out_idx);
      end
      checks++;
      #1 rst = 0;
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== 32'd0) begin
         failures++; $display("FAIL t5_async got=v%b b%b d%b data%0d exp=0,0,0,0", out_valid, busy, done, out_data);
      end
      checks++;
      @(negedge clk); rst = 1;
      @(negedge clk);
      op_a[0] = 3; op_b[0] = 7;
      run_job(8'd1, 2, 0, 0, 60);
      if (r_w[0] !== 32'd21 || r_w[1] !== 32'd35 || r_ndone !== 1) begin
         failures++; $display("FAIL t5_fresh got=%0d,%0d done%0d exp=21,35,1", r_w[0], r_w[1], r_ndone);
      end
      checks++;
   endtask

   task automatic test_zero_len;
      run_job(8'd0, 0, 0, 0, 12);
      if (r_busy || r_nfeed !== 0 || r_nclr !== 0 || r_ndone !== 0 || r_nw !== 0) begin
         failures++; $display("FAIL t6_zero got=busy%0d feed%0d clr%0d done%0d words%0d exp=0,0,0,0,0", r_busy, r_nfeed, r_nclr, r_ndone, r_nw);
      end
      checks++;
   endtask

   initial begin
      test_reset;
      test_single;
      test_two_cycle;
      test_backpressure;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid_drain;
      test_zero_len;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
